apb_timer_slave: RTL and testbench

//  APB3/APB4 completer downstream of the AHB-to-APB bridge; consumes PSEL/PENABLE/PSTRB/PPROT, returns PRDATA/PREADY/PSLVERR.

---
 rtl/apb_timer_slave.sv | 171 +++++++++++++++++
 tb/tb_apb_timer_slave.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_timer_slave.sv
// rtl/apb_timer_slave.sv - APB completer with wait states and a reloading 32-bit down-counter timer.
// Optional macro APB_TIMER_PROT_CHECK_EN: unprivileged writes to mapped offsets get PSLVERR.
module apb_timer_slave #(
  parameter int ADDRWIDTH   = 12,
  parameter int WAIT_STATES = 1
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  input  logic                 PSEL,
  input  logic [ADDRWIDTH-1:0] PADDR,
  input  logic                 PENABLE,
  input  logic                 PWRITE,
  input  logic [3:0]           PSTRB,
  input  logic [2:0]           PPROT,
  input  logic [31:0]          PWDATA,
  output logic [31:0]          PRDATA,
  output logic                 PREADY,
  output logic                 PSLVERR,
  input  logic                 EXTIN,
  output logic                 TIMERINT
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [1:0] WAIT_INIT = 2'(WAIT_STATES);

  state_t      state, state_nxt;
  logic [1:0]  wait_cnt, wait_cnt_nxt;
  logic        access_done;

  logic [3:0]  ctrl, ctrl_nxt;
  logic [31:0] value, value_nxt;
  logic [31:0] reload, reload_nxt;
  logic        int_status, int_nxt;
  logic        ext_meta, ext_sync, ext_sync_d;

  logic [ADDRWIDTH-3:0] word;
  logic [1:0]  sel;
  logic        mapped, prot_err, wr_commit;
  logic        wr_ctrl, wr_value, wr_reload, int_clr, int_set;
  logic        ext_rise, tick, dec;
  logic [31:0] rd_mux;
  logic        unused_inputs;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++)
      if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
    return r;
  endfunction

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // PREADY is held low only while an access phase still owes wait cycles.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    PREADY       = 1'b1;
    access_done  = 1'b0;
    case (state)
      S_IDLE: begin
        if (PSEL && !PENABLE) begin
          state_nxt    = S_WAIT;
          wait_cnt_nxt = WAIT_INIT;
        end
      end
      S_WAIT: begin
        if (!PSEL) begin
          state_nxt = S_IDLE;
        end else if (PENABLE) begin
          if (wait_cnt != 2'd0) begin
            PREADY       = 1'b0;
            wait_cnt_nxt = wait_cnt - 2'd1;
          end else begin
            access_done = 1'b1;
            state_nxt   = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign word   = PADDR[ADDRWIDTH-1:2];
  assign sel    = word[1:0];
  assign mapped = (word[ADDRWIDTH-3:2] == '0);

`ifdef APB_TIMER_PROT_CHECK_EN
  assign prot_err = PWRITE & ~PPROT[0] & mapped;
`else
  assign prot_err = 1'b0;
`endif

  assign unused_inputs = ^{PPROT, PADDR[1:0]};

  assign PSLVERR   = access_done & (~mapped | prot_err);
  assign wr_commit = access_done & PWRITE & ~PSLVERR;
  assign wr_ctrl   = wr_commit & (sel == 2'd0) & PSTRB[0];
  assign wr_value  = wr_commit & (sel == 2'd1) & (|PSTRB);
  assign wr_reload = wr_commit & (sel == 2'd2) & (|PSTRB);
  assign int_clr   = wr_commit & (sel == 2'd3) & PSTRB[0] & PWDATA[0];

  always_comb begin
    rd_mux = '0;
    if (mapped) begin
      case (sel)
        2'd0:    rd_mux = {28'd0, ctrl};
        2'd1:    rd_mux = value;
        2'd2:    rd_mux = reload;
        default: rd_mux = {31'd0, int_status};
      endcase
    end
  end

  assign PRDATA = (access_done && !PWRITE && !PSLVERR) ? rd_mux : 32'd0;

  assign ext_rise = ext_sync & ~ext_sync_d;
  assign tick     = ctrl[2] ? ext_rise : 1'b1;
  assign dec      = ctrl[0] & (~ctrl[1] | ext_sync) & tick;
  assign int_set  = dec & (value == 32'd1);

  // A VALUE write overrides a decrement in the same cycle; interrupt set beats clear.
  always_comb begin
    ctrl_nxt   = ctrl;
    value_nxt  = value;
    reload_nxt = reload;
    int_nxt    = int_set | (int_status & ~int_clr);
    if (wr_ctrl)
      ctrl_nxt = PWDATA[3:0];
    if (wr_reload)
      reload_nxt = byte_merge(reload, PWDATA, PSTRB);
    if (wr_value)
      value_nxt = byte_merge(value, PWDATA, PSTRB);
    else if (dec)
      value_nxt = (value <= 32'd1) ? reload : value - 32'd1;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      ctrl       <= '0;
      value      <= '0;
      reload     <= '0;
      int_status <= 1'b0;
      TIMERINT   <= 1'b0;
      ext_meta   <= 1'b0;
      ext_sync   <= 1'b0;
      ext_sync_d <= 1'b0;
    end else begin
      ctrl       <= ctrl_nxt;
      value      <= value_nxt;
      reload     <= reload_nxt;
      int_status <= int_nxt;
      TIMERINT   <= int_nxt & ctrl_nxt[3];
      ext_meta   <= EXTIN;
      ext_sync   <= ext_meta;
      ext_sync_d <= ext_sync;
    end
  end

endmodule

// File: tb/tb_apb_timer_slave.sv
// tb/tb_apb_timer_slave.sv - directed and randomized check of apb_timer_slave against a cycle model.
module tb_apb_timer_slave;
  localparam int WS = 1;
`ifdef APB_TIMER_PROT_CHECK_EN
  localparam bit PROT_EN = 1'b1;
`else
  localparam bit PROT_EN = 1'b0;
`endif

  logic        PCLK = 1'b0;
  logic        PRESETn, PSEL, PENABLE, PWRITE, EXTIN;
  logic [11:0] PADDR;
  logic [3:0]  PSTRB;
  logic [2:0]  PPROT;
  logic [31:0] PWDATA, PRDATA;
  logic        PREADY, PSLVERR, TIMERINT;

  apb_timer_slave #(.ADDRWIDTH(12), .WAIT_STATES(WS)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PADDR(PADDR), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PSTRB(PSTRB), .PPROT(PPROT), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .EXTIN(EXTIN), .TIMERINT(TIMERINT)
  );

  always #5 PCLK = ~PCLK;

  int total = 0;
  int bad   = 0;

  logic [3:0]  m_ctrl;
  logic [31:0] m_value, m_reload;
  logic        m_is;
  bit          q_ext[$];
  bit          ext_rand = 1'b0;
  bit          in_reset = 1'b0;
  logic [31:0] rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] mreg(input logic [11:0] a);
    if (a[11:4] != 0) return 32'd0;
    case (a[3:2])
      2'd0:    return {28'd0, m_ctrl};
      2'd1:    return m_value;
      2'd2:    return m_reload;
      default: return {31'd0, m_is};
    endcase
  endfunction

  task automatic model_reset();
    m_ctrl = 0; m_value = 0; m_reload = 0; m_is = 0;
    q_ext.delete();
    repeat (3) q_ext.push_back(1'b0);
  endtask

  // One clock edge of the register/timer behaviour, given the write (if any) that commits now.
  task automatic model_edge(input bit wr, input logic [11:0] a, input logic [3:0] s, input logic [31:0] d);
    bit sync, prev, tick, dec, set, clr;
    logic [3:0]  nctrl;
    logic [31:0] nval, nrel;
    if (in_reset) begin
      model_reset();
      return;
    end
    sync = q_ext[1];
    prev = q_ext[0];
    q_ext.push_back(EXTIN);
    void'(q_ext.pop_front());
    tick = m_ctrl[2] ? (sync & ~prev) : 1'b1;
    dec  = m_ctrl[0] & (~m_ctrl[1] | sync) & tick;
    nctrl = m_ctrl; nval = m_value; nrel = m_reload; set = 0; clr = 0;
    if (dec) begin
      if (m_value == 1) begin nval = m_reload; set = 1; end
      else if (m_value == 0) nval = m_reload;
      else nval = m_value - 1;
    end
    if (wr && a[11:4] == 0) begin
      case (a[3:2])
        2'd0: if (s[0]) nctrl = d[3:0];
        2'd1: if (s != 0) nval = merge(m_value, d, s);
        2'd2: nrel = merge(m_reload, d, s);
        default: clr = s[0] & d[0];
      endcase
    end
    m_ctrl = nctrl; m_value = nval; m_reload = nrel;
    m_is = set | (m_is & ~clr);
  endtask

  task automatic step(input bit wr, input logic [11:0] a, input logic [3:0] s, input logic [31:0] d);
    @(posedge PCLK);
    model_edge(wr, a, s, d);
    @(negedge PCLK);
    chk("timerint", {31'd0, TIMERINT}, {31'd0, m_is & m_ctrl[3]});
    if (ext_rand) EXTIN = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  task automatic apb(input bit w, input logic [11:0] a, input logic [3:0] s, input logic [31:0] d,
                     input logic [2:0] p, input string tag, output logic [31:0] rdata);
    bit err;
    logic [31:0] exp_rd;
    PSEL = 1; PENABLE = 0; PWRITE = w; PADDR = a; PSTRB = w ? s : 4'd0; PWDATA = d; PPROT = p;
    step(0, 0, 0, 0);
    PENABLE = 1;
    for (int i = 0; i < WS; i++) begin
      #1 chk({tag, "_wait_pready"}, {31'd0, PREADY}, 32'd0);
      step(0, 0, 0, 0);
    end
    #1;
    err = (a[11:4] != 0) | (PROT_EN & w & ~p[0]);
    exp_rd = (w | err) ? 32'd0 : mreg(a);
    chk({tag, "_pready"}, {31'd0, PREADY}, 32'd1);
    chk({tag, "_pslverr"}, {31'd0, PSLVERR}, {31'd0, err});
    chk({tag, "_prdata"}, PRDATA, exp_rd);
    rdata = PRDATA;
    step(w & ~err, a, s, d);
    PSEL = 0; PENABLE = 0; PWRITE = 0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d, input string tag);
    logic [31:0] dummy;
    apb(1, a, 4'hF, d, 3'b001, tag, dummy);
  endtask

  initial begin
    logic [31:0] d;
    logic [11:0] a;
    PRESETn = 0; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PSTRB = 0;
    PPROT = 0; PWDATA = 0; EXTIN = 0;
    in_reset = 1;
    model_reset();
    idle(2);
    chk("reset_pready", {31'd0, PREADY}, 32'd1);
    chk("reset_prdata", PRDATA, 32'd0);
    chk("reset_pslverr", {31'd0, PSLVERR}, 32'd0);
    PRESETn = 1; in_reset = 0;

    apb(0, 12'h008, 0, 0, 3'b001, "rd_reload_reset", rd);
    chk("reload_reset_val", rd, 32'd0);

    wr(12'h008, 32'd3, "wr_reload");
    wr(12'h004, 32'd3, "wr_value");
    wr(12'h000, 32'h9, "wr_ctrl9");
    for (int i = 0; i < 20 && !TIMERINT; i++) step(0, 0, 0, 0);
    chk("int_rise", {31'd0, TIMERINT}, 32'd1);
    idle(7);
    wr(12'h000, 32'h8, "wr_ctrl8");
    chk("int_held", {31'd0, TIMERINT}, 32'd1);
    wr(12'h00C, 32'd1, "int_clear");
    chk("int_cleared", {31'd0, TIMERINT}, 32'd0);

    wr(12'h000, 32'h0, "wr_ctrl0");
    wr(12'h004, 32'h0, "wr_value0");
    apb(1, 12'h004, 4'b0101, 32'hAABBCCDD, 3'b001, "wr_strb", rd);
    apb(0, 12'h004, 0, 0, 3'b001, "rd_strb", rd);
    chk("strb_value", rd, 32'h00BB00DD);
    apb(1, 12'h008, 4'b0000, 32'hFFFFFFFF, 3'b001, "wr_nostrb", rd);

    apb(0, 12'h010, 0, 0, 3'b001, "rd_unmapped", rd);
    apb(1, 12'h014, 4'hF, 32'hFFFFFFFF, 3'b001, "wr_unmapped", rd);
    for (int i = 0; i < 4; i++) apb(0, 12'(4 * i), 0, 0, 3'b001, "rd_after_unmapped", rd);

    wr(12'h004, 32'd100, "wr_value100");
    wr(12'h000, 32'h5, "wr_ctrl5");
    idle(4);
    for (int i = 0; i < 4; i++) begin
      EXTIN = 1; idle(2);
      EXTIN = 0; idle(2);
    end
    idle(4);
    apb(0, 12'h004, 0, 0, 3'b001, "rd_extclk", rd);
    chk("extclk_value", rd, 32'd96);
    idle(10);
    apb(0, 12'h004, 0, 0, 3'b001, "rd_extstatic", rd);
    chk("extstatic_value", rd, 32'd96);

    wr(12'h000, 32'h0, "wr_ctrl_clr");
    apb(1, 12'h000, 4'hF, 32'h3, 3'b000, "wr_ctrl_unpriv", rd);
    apb(0, 12'h000, 0, 0, 3'b001, "rd_ctrl_unpriv", rd);
    chk("ctrl_unpriv", rd, PROT_EN ? 32'h0 : 32'h3);
    apb(1, 12'h000, 4'hF, 32'h2, 3'b001, "wr_ctrl_priv", rd);
    apb(0, 12'h000, 0, 0, 3'b001, "rd_ctrl_priv", rd);
    chk("ctrl_priv", rd, 32'h2);

    wr(12'h008, 32'd4, "rnd_reload");
    wr(12'h000, 32'h1, "rnd_ctrl");
    ext_rand = 1;
    for (int n = 0; n < 150; n++) begin
      a = 12'($urandom_range(0, 31));
      d = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 6)) : $urandom;
      apb(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), d,
          3'($urandom_range(0, 7)), "rnd", rd);
      idle($urandom_range(0, 3));
    end
    ext_rand = 0;
    EXTIN = 0;
    for (int i = 0; i < 4; i++) apb(0, 12'(4 * i), 0, 0, 3'b001, "rnd_sweep", rd);

    wr(12'h000, 32'h0, "rst_ctrl0");
    wr(12'h008, 32'd5, "rst_reload");
    wr(12'h004, 32'd1, "rst_value");
    wr(12'h000, 32'h9, "rst_ctrl9");
    idle(3);
    chk("int_before_reset", {31'd0, TIMERINT}, 32'd1);
    PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = 12'h008;
    step(0, 0, 0, 0);
    PENABLE = 1;
    #1 chk("midwait_pready", {31'd0, PREADY}, 32'd0);
    PRESETn = 0; in_reset = 1;
    #1;
    chk("rst_pready", {31'd0, PREADY}, 32'd1);
    chk("rst_pslverr", {31'd0, PSLVERR}, 32'd0);
    chk("rst_prdata", PRDATA, 32'd0);
    chk("rst_timerint", {31'd0, TIMERINT}, 32'd0);
    PSEL = 0; PENABLE = 0;
    idle(2);
    PRESETn = 1; in_reset = 0;
    for (int i = 0; i < 4; i++) begin
      apb(0, 12'(4 * i), 0, 0, 3'b001, "rd_post_reset", rd);
      chk("post_reset_zero", rd, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
